head_rewrite_arbiter: RTL and testbench

Packet-granularity round-robin arbiter that shares one head-flit rewrite stage and one output link among `NUM_PORTS` input streams. The winning port owns the output from head flit through tail flit. While the head flit passes through, its hop-count field is rewritten, in the same way the head-flit updater substitutes a new head flit. The block sits between the input buffers of a router output port and the output link register.

---
 rtl/head_rewrite_arbiter.sv | 169 ++++++++++++++++
 tb/tb_head_rewrite_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/head_rewrite_arbiter.sv
// ============================================================================
// head_rewrite_arbiter
//   Packet-locked round-robin arbiter with optional head-flit hop rewrite.
//   Optional feature macro: HEAD_HOP_COUNT_EN (saturating hop increment).
//   Rev 1.0
// ============================================================================
`default_nettype none

module head_rewrite_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int TYPE_WIDTH = 2,
    parameter int NUM_PORTS  = 4,
    parameter int HOP_WIDTH  = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_PORTS-1:0]            in_valid,
    output logic [NUM_PORTS-1:0]            in_ready,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [NUM_PORTS-1:0]            grant,
    output logic                            proto_err
);

    localparam int                    c_PW   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [TYPE_WIDTH-1:0] c_HEAD = TYPE_WIDTH'(1);
    localparam logic [TYPE_WIDTH-1:0] c_TAIL = TYPE_WIDTH'(3);
    localparam logic [TYPE_WIDTH-1:0] c_BODY = TYPE_WIDTH'(2);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    state_t                  r_state, w_state_nxt;
    logic [c_PW-1:0]         r_owner, w_owner_nxt;
    logic [c_PW-1:0]         r_rr_ptr, w_rr_nxt;
    logic [NUM_PORTS-1:0]    r_grant, w_grant_nxt;
    logic [DATA_WIDTH-1:0]   r_out_data;
    logic                    r_out_valid;
    logic                    r_proto_err;

    logic [DATA_WIDTH-1:0]   w_flit [NUM_PORTS];
    logic [NUM_PORTS-1:0]    w_is_head;
    logic [NUM_PORTS-1:0]    w_elig;
    logic                    w_can_load;
    logic                    w_found;
    logic [c_PW-1:0]         w_win;
    logic [c_PW-1:0]         w_sel;
    logic [DATA_WIDTH-1:0]   w_sel_flit;
    logic [TYPE_WIDTH-1:0]   w_sel_type;
    logic [DATA_WIDTH-1:0]   w_out_nxt;
    logic [NUM_PORTS-1:0]    w_in_ready;
    logic                    w_load;
    logic                    w_set_err;

    generate
        for (genvar k = 0; k < NUM_PORTS; k++) begin : g_port
            assign w_flit[k]    = in_data[k*DATA_WIDTH +: DATA_WIDTH];
            assign w_is_head[k] = (w_flit[k][DATA_WIDTH-1 -: TYPE_WIDTH] == c_HEAD);
        end
    endgenerate

    assign w_elig     = in_valid & w_is_head;
    assign w_can_load = !r_out_valid || out_ready;

    // First eligible head at or above the round-robin pointer, with wrap.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!w_found && w_elig[c_PW'((int'(r_rr_ptr) + i) % NUM_PORTS)]) begin
                w_found = 1'b1;
                w_win   = c_PW'((int'(r_rr_ptr) + i) % NUM_PORTS);
            end
        end
    end

    assign w_sel_flit = w_flit[w_sel];
    assign w_sel_type = w_sel_flit[DATA_WIDTH-1 -: TYPE_WIDTH];

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_grant_nxt = r_grant;
        w_rr_nxt    = r_rr_ptr;
        w_in_ready  = '0;
        w_load      = 1'b0;
        w_sel       = r_owner;
        w_set_err   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_sel     = w_win;
                w_set_err = |(in_valid & ~w_is_head);
                if (w_found && w_can_load) begin
                    w_in_ready[w_win] = 1'b1;
                    w_load            = 1'b1;
                    w_state_nxt       = S_LOCKED;
                    w_owner_nxt       = w_win;
                    w_grant_nxt       = '0;
                    w_grant_nxt[w_win] = 1'b1;
                    w_rr_nxt          = c_PW'((int'(w_win) + 1) % NUM_PORTS);
                end
            end
            S_LOCKED: begin
                w_in_ready[r_owner] = w_can_load;
                if (in_valid[r_owner] && w_can_load) begin
                    w_load = 1'b1;
                    if (w_sel_type == c_TAIL) begin
                        w_state_nxt = S_IDLE;
                        w_grant_nxt = '0;
                    end else if (w_sel_type != c_BODY) begin
                        w_set_err = 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

`ifdef HEAD_HOP_COUNT_EN
    // Only the arbitration-winning head is rewritten; stray heads inside a packet pass as-is.
    always_comb begin
        w_out_nxt = w_sel_flit;
        if (r_state == S_IDLE && w_sel_type == c_HEAD && w_sel_flit[HOP_WIDTH-1:0] != '1) begin
            w_out_nxt[HOP_WIDTH-1:0] = w_sel_flit[HOP_WIDTH-1:0] + 1'b1;
        end
    end
`else
    assign w_out_nxt = w_sel_flit;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_owner     <= '0;
            r_rr_ptr    <= '0;
            r_grant     <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_owner  <= w_owner_nxt;
            r_rr_ptr <= w_rr_nxt;
            r_grant  <= w_grant_nxt;
            if (w_load) begin
                r_out_data  <= w_out_nxt;
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_set_err) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign grant     = r_grant;
    assign proto_err = r_proto_err;

endmodule

`default_nettype wire

// File: tb/tb_head_rewrite_arbiter.sv
// ============================================================================
// tb_head_rewrite_arbiter
//   Directed self-checking bench for head_rewrite_arbiter.
//   Rev 1.0
// ============================================================================
`default_nettype none

module tb_head_rewrite_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] in_data;
    logic [3:0]   in_valid;
    logic [3:0]   in_ready;
    logic [31:0]  out_data;
    logic         out_valid;
    logic         out_ready;
    logic [3:0]   grant;
    logic         proto_err;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] pkt [8];
    logic [31:0] got [8];
    int          ngot;

    head_rewrite_arbiter #(
        .DATA_WIDTH(32), .TYPE_WIDTH(2), .NUM_PORTS(4), .HOP_WIDTH(4)
    ) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .grant(grant), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected output for a winning head flit.
    function automatic logic [31:0] hexp(input logic [31:0] f);
        logic [31:0] r;
        r = f;
`ifdef HEAD_HOP_COUNT_EN
        if (f[3:0] != 4'hF) r[3:0] = f[3:0] + 4'd1;
`endif
        return r;
    endfunction

    task automatic drive(input int p, input logic [31:0] d, input logic v);
        in_data[p*32 +: 32] = d;
        in_valid[p]         = v;
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        in_data   = '0;
        in_valid  = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Single-port packet source with an optional out_ready stall window.
    task automatic send_port(input int p, input int n, input int ss, input int sl);
        int          idx;
        logic [31:0] held;
        idx  = 0;
        ngot = 0;
        held = '0;
        for (int c = 0; c < 60 && ngot < n; c++) begin
            @(posedge clk); #1;
            out_ready = !(c >= ss && c < ss + sl);
            if (idx < n) drive(p, pkt[idx], 1'b1);
            else         drive(p, 32'h0, 1'b0);
            @(negedge clk);
            if (c == ss) held = out_data;
            if (c >= ss && c < ss + sl) begin
                n_cmp++;
                if (in_ready !== 4'b0000 || out_data !== held || out_valid !== 1'b1) begin
                    n_err++;
                    $display("FAIL stall c=%0d: in_ready=%b out_data=%h out_valid=%b, required in_ready=0000 out_data=%h out_valid=1",
                             c, in_ready, out_data, out_valid, held);
                end
            end
            if (in_valid[p] && in_ready[p]) idx++;
            if (out_valid && out_ready) begin
                got[ngot] = out_data;
                ngot++;
            end
        end
        @(posedge clk); #1;
        drive(p, 32'h0, 1'b0);
        out_ready = 1'b1;
        n_cmp++;
        if (ngot != n) begin
            n_err++;
            $display("FAIL send_port count: got %0d flits, required %0d", ngot, n);
        end
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL send_port extra flit: out_valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || grant !== 4'h0 ||
            proto_err !== 1'b0 || in_ready !== 4'h0) begin
            n_err++;
            $display("FAIL reset: out_valid=%b out_data=%h grant=%b proto_err=%b in_ready=%b, required all 0",
                     out_valid, out_data, grant, proto_err, in_ready);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        @(posedge clk); #1;
        drive(2, 32'h4000_0003, 1'b1);
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 4'b0100 || grant !== 4'b0000) begin
            n_err++;
            $display("FAIL single arb: in_ready=%b grant=%b, required 0100 0000", in_ready, grant);
        end
        @(posedge clk); #1;
        drive(2, 32'h8000_00AA, 1'b1);
        @(negedge clk);
        n_cmp++;
        if (out_data !== hexp(32'h4000_0003) || out_valid !== 1'b1 || grant !== 4'b0100 || in_ready !== 4'b0100) begin
            n_err++;
            $display("FAIL single head: out_data=%h out_valid=%b grant=%b in_ready=%b, required %h 1 0100 0100",
                     out_data, out_valid, grant, in_ready, hexp(32'h4000_0003));
        end
        @(posedge clk); #1;
        drive(2, 32'hC000_00BB, 1'b1);
        @(negedge clk);
        n_cmp++;
        if (out_data !== 32'h8000_00AA || grant !== 4'b0100) begin
            n_err++;
            $display("FAIL single body: out_data=%h grant=%b, required 800000aa 0100", out_data, grant);
        end
        @(posedge clk); #1;
        drive(2, 32'h0, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (out_data !== 32'hC000_00BB || out_valid !== 1'b1 || grant !== 4'b0000) begin
            n_err++;
            $display("FAIL single tail: out_data=%h out_valid=%b grant=%b, required c00000bb 1 0000",
                     out_data, out_valid, grant);
        end
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL single drain: out_valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [31:0] pk [4][2];
        logic [31:0] ex [8];
        int          ptr [4];
        int          ng;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            pk[k][0]     = 32'h4000_0001 + 32'h100 * (k + 1);
            pk[k][1]     = 32'hC000_0000 + k;
            ex[2*k]      = hexp(pk[k][0]);
            ex[2*k + 1]  = pk[k][1];
            ptr[k]       = 0;
        end
        ng = 0;
        for (int c = 0; c < 40 && ng < 8; c++) begin
            @(posedge clk); #1;
            for (int k = 0; k < 4; k++) begin
                if (ptr[k] < 2) drive(k, pk[k][ptr[k]], 1'b1);
                else            drive(k, 32'h0, 1'b0);
            end
            @(negedge clk);
            n_cmp++;
            if ($countones(in_ready) > 1 || $countones(grant) > 1) begin
                n_err++;
                $display("FAIL rr onehot c=%0d: in_ready=%b grant=%b, required at most one bit", c, in_ready, grant);
            end
            for (int k = 0; k < 4; k++) begin
                if (in_valid[k] && in_ready[k]) ptr[k]++;
            end
            if (out_valid && out_ready) begin
                got[ng] = out_data;
                ng++;
            end
        end
        @(posedge clk); #1;
        in_valid = '0;
        n_cmp++;
        if (ng != 8) begin
            n_err++;
            $display("FAIL rr count: got %0d flits, required 8", ng);
        end
        for (int i = 0; i < ng; i++) begin
            n_cmp++;
            if (got[i] !== ex[i]) begin
                n_err++;
                $display("FAIL rr order[%0d]: out_data=%h, required %h", i, got[i], ex[i]);
            end
        end
    endtask

    task automatic test_hop();
`ifdef HEAD_HOP_COUNT_EN
        pkt[0] = 32'h4000_000F;
`else
        pkt[0] = 32'h4000_0003;
`endif
        pkt[1] = 32'hC000_0055;
        send_port(0, 2, 99, 0);
        n_cmp++;
        if (got[0] !== pkt[0] || got[1] !== 32'hC000_0055) begin
            n_err++;
            $display("FAIL hop: head=%h tail=%h, required %h c0000055", got[0], got[1], pkt[0]);
        end
    endtask

    task automatic test_stall();
        pkt[0] = 32'h4000_0105;
        pkt[1] = 32'h8000_0011;
        pkt[2] = 32'h8000_0022;
        pkt[3] = 32'hC000_0033;
        send_port(1, 4, 2, 5);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (got[i] !== ((i == 0) ? hexp(pkt[0]) : pkt[i])) begin
                n_err++;
                $display("FAIL stall seq[%0d]: out_data=%h, required %h",
                         i, got[i], (i == 0) ? hexp(pkt[0]) : pkt[i]);
            end
        end
    endtask

    task automatic test_proto_err();
        do_reset();
        @(posedge clk); #1;
        drive(1, 32'h8000_0001, 1'b1);
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 4'b0000) begin
            n_err++;
            $display("FAIL proto accept: in_ready=%b, required 0000", in_ready);
        end
        @(posedge clk); #1;
        drive(1, 32'h0, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (proto_err !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL proto set: proto_err=%b out_valid=%b, required 1 0", proto_err, out_valid);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (proto_err !== 1'b1) begin
            n_err++;
            $display("FAIL proto sticky: proto_err=%b, required 1", proto_err);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (proto_err !== 1'b0) begin
            n_err++;
            $display("FAIL proto clear: proto_err=%b, required 0", proto_err);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset_mid();
        do_reset();
        @(posedge clk); #1;
        drive(2, 32'h4000_0001, 1'b1);
        @(posedge clk); #1;
        drive(2, 32'h8000_0002, 1'b1);
        rst = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || grant !== 4'b0000) begin
            n_err++;
            $display("FAIL midreset: out_valid=%b grant=%b, required 0 0000", out_valid, grant);
        end
        in_valid = '0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        drive(1, 32'h4000_0101, 1'b1);
        drive(3, 32'h4000_0301, 1'b1);
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 4'b0010) begin
            n_err++;
            $display("FAIL midreset rr_ptr: in_ready=%b, required 0010", in_ready);
        end
        @(posedge clk); #1;
        drive(1, 32'hC000_0101, 1'b1);
        @(negedge clk);
        n_cmp++;
        if (grant !== 4'b0010 || out_data !== hexp(32'h4000_0101)) begin
            n_err++;
            $display("FAIL midreset p1: grant=%b out_data=%h, required 0010 %h",
                     grant, out_data, hexp(32'h4000_0101));
        end
        @(posedge clk); #1;
        drive(1, 32'h0, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 4'b1000 || grant !== 4'b0000) begin
            n_err++;
            $display("FAIL midreset p3 arb: in_ready=%b grant=%b, required 1000 0000", in_ready, grant);
        end
        @(posedge clk); #1;
        drive(3, 32'hC000_0301, 1'b1);
        @(negedge clk);
        n_cmp++;
        if (grant !== 4'b1000 || out_data !== hexp(32'h4000_0301)) begin
            n_err++;
            $display("FAIL midreset p3: grant=%b out_data=%h, required 1000 %h",
                     grant, out_data, hexp(32'h4000_0301));
        end
        @(posedge clk); #1;
        drive(3, 32'h0, 1'b0);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        rst       = 1'b0;
        in_data   = '0;
        in_valid  = '0;
        out_ready = 1'b1;
        test_reset();
        test_single();
        test_round_robin();
        test_hop();
        test_stall();
        test_proto_err();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
